// File: rtl/multiplicador_secuencial_4b_pkg.sv
// rtl/multiplicador_secuencial_4b_pkg.sv - shared constants for the 4x4 sequential multiplier
package multiplicador_secuencial_4b_pkg;

   // FSM encodings; 2'd3 is unused and falls back to IDLE
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   // One shift-and-add iteration per multiplier bit
   localparam int         N_ITER   = 4;
   localparam logic [1:0] CNT_LAST = 2'(N_ITER - 1);

   // busy covers both the iteration phase and the done cycle
   function automatic logic state_is_busy(input logic [1:0] st);
      return (st == ST_CALC) || (st == ST_FIN);
   endfunction

endpackage

// File: rtl/sumador_4b.sv
// rtl/sumador_4b.sv - 4-bit ripple-carry adder used for the partial sums
module sumador_4b (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic [3:0] s_o,
   output logic       c_o
);

   logic [4:0] carry;

   // Ripple the carry bit by bit; carry out is kept so the product never overflows
   always_comb begin
      s_o      = '0;
      carry    = '0;
      carry[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
         carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
      end
      c_o = carry[4];
   end

endmodule

// File: rtl/multiplicador_secuencial_4b.sv
// rtl/multiplicador_secuencial_4b.sv - unsigned 4x4 shift-and-add multiplier with start/busy/done
module multiplicador_secuencial_4b
   import multiplicador_secuencial_4b_pkg::*;
#(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   output logic [2*N-1:0] P,
   output logic           busy,
   output logic           done
);

   if (N != 4) begin : g_bad_width
      $error("multiplicador_secuencial_4b supports only N=4");
   end

   logic [1:0] state_q, state_d;
   logic [3:0] a_q, a_d;
   logic [3:0] hi_q, hi_d;
   logic [3:0] lo_q, lo_d;
   logic [1:0] cnt_q, cnt_d;
   logic       done_q, done_d;

   logic [3:0] sum_s;
   logic       sum_c;

   sumador_4b u_sumador (
      .a_i (hi_q),
      .b_i (a_q),
      .s_o (sum_s),
      .c_o (sum_c)
   );

   // Next-state: accept in IDLE, one shift(-add) per CALC cycle, single done cycle in FIN
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = A;
               hi_d    = '0;
               lo_d    = B;
               cnt_d   = '0;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            if (lo_q[0]) begin
               hi_d = {sum_c, sum_s[3:1]};
               lo_d = {sum_s[0], lo_q[3:1]};
            end else begin
               hi_d = {1'b0, hi_q[3:1]};
               lo_d = {hi_q[0], lo_q[3:1]};
            end
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FIN;
               done_d  = 1'b1;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign P    = {hi_q, lo_q};
   assign busy = state_is_busy(state_q);
   assign done = done_q;

endmodule

// File: tb/tb_multiplicador_secuencial_4b.sv
// tb/tb_multiplicador_secuencial_4b.sv - scoreboard bench for the sequential multiplier
module tb_multiplicador_secuencial_4b;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [3:0] A     = '0;
   logic [3:0] B     = '0;
   logic [7:0] P;
   logic       busy;
   logic       done;

   always #5 clk = ~clk;

   multiplicador_secuencial_4b #(.N(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .P     (P),
      .busy  (busy),
      .done  (done)
   );

   typedef struct {
      logic [7:0] prod;
      int         due;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   last_acc = -100;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: an accepted start owns the unit for 6 edges and yields A*B 4 edges later
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            sb.delete();
            last_acc = -100;
         end else begin
            cyc++;
            if (start && (cyc >= last_acc + 6)) begin
               sb.push_back('{prod: 8'(int'(A) * int'(B)), due: cyc + 4});
               last_acc = cyc;
            end
         end
      end
   end

   // Monitor: compares busy/done every cycle and pops the product on each done pulse
   initial begin
      logic exp_done;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            exp_done = (sb.size() > 0) && (sb[0].due == cyc);
            check("busy", 32'(busy), 32'((cyc >= last_acc) && (cyc <= last_acc + 4)));
            check("done", 32'(done), 32'(exp_done));
            if (exp_done) begin
               check("product", 32'(P), 32'(sb[0].prod));
               void'(sb.pop_front());
            end
         end
      end
   end

   task automatic do_op(input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      start = 1'b1;
      A     = a;
      B     = b;
      @(negedge clk);
      start = 1'b0;
      A     = 4'($urandom);
      B     = 4'($urandom);
      repeat (5) @(negedge clk);
   endtask

   initial begin
      logic [3:0] corner_a [4];
      logic [3:0] corner_b [4];
      corner_a = '{4'd0, 4'd15, 4'd15, 4'd1};
      corner_b = '{4'd13, 4'd15, 4'd1, 4'd15};

      // Asynchronous reset with random inputs, checked before any clock edge
      start = 1'($urandom);
      A     = 4'($urandom);
      B     = 4'($urandom);
      #2 rst_n = 1'b0;
      #1;
      check("reset P", 32'(P), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Basic operation and corners
      do_op(4'd7, 4'd3);
      for (int i = 0; i < 4; i++) do_op(corner_a[i], corner_b[i]);

      // start held high; operands scrambled whenever the next edge cannot accept
      @(negedge clk);
      start = 1'b1;
      A     = 4'd5;
      B     = 4'd6;
      repeat (30) begin
         @(negedge clk);
         if (cyc + 1 >= last_acc + 6) begin
            A = 4'd5;
            B = 4'd6;
         end else begin
            A = 4'($urandom);
            B = 4'($urandom);
         end
      end
      start = 1'b0;
      repeat (8) @(negedge clk);

      // Reset after two CALC edges, then a fresh operation
      @(negedge clk);
      start = 1'b1;
      A     = 4'd9;
      B     = 4'd9;
      @(negedge clk);
      start = 1'b0;
      A     = 4'($urandom);
      B     = 4'($urandom);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midop reset P", 32'(P), 32'd0);
      check("midop reset busy", 32'(busy), 32'd0);
      check("midop reset done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(4'd2, 4'd3);

      // Exhaustive sweep
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            do_op(4'(a), 4'(b));

      // Random start traffic, including starts while busy
      repeat (400) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         A     = 4'($urandom);
         B     = 4'($urandom);
      end
      start = 1'b0;
      repeat (8) @(negedge clk);

      check("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
